// File: rtl/mram_power_arbiter.sv
// Arbitrates shared access to the MRAM power sequencer between N_REQ requesters,
// with idle power-down, a sequence watchdog and a saturating power-up counter.
module mram_power_arbiter #(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned TIMEOUT_W   = 16,
    parameter int unsigned SEQ_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_i,
    output logic [N_REQ-1:0]     gnt_o,
    input  logic [TIMEOUT_W-1:0] idle_timeout_i,
    output logic                 pg_power_o,
    input  logic                 pg_done_i,
    output logic [2:0]           state_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     on_cnt_o
);

    localparam int unsigned SW = (SEQ_TIMEOUT > 2) ? $clog2(SEQ_TIMEOUT) : 1;
    localparam logic [SW-1:0] SEQ_MAX = SW'(SEQ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        UP   = 3'd1,
        ON   = 3'd2,
        IDLE = 3'd3,
        DOWN = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 pg_power_q, pg_power_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     on_cnt_q, on_cnt_d;
    logic [SW-1:0]        seq_cnt_q, seq_cnt_d;
    logic [TIMEOUT_W-1:0] idle_cnt_q, idle_cnt_d;

    logic any_req;
    assign any_req = |req_i;

    always_comb begin
        state_d    = state_q;
        pg_power_d = pg_power_q;
        gnt_d      = gnt_q;
        err_d      = err_q;
        on_cnt_d   = on_cnt_q;
        seq_cnt_d  = seq_cnt_q;
        idle_cnt_d = idle_cnt_q;

        case (state_q)
            OFF: begin
                gnt_d = '0;
                if (any_req) begin
                    state_d    = UP;
                    pg_power_d = 1'b1;
                    seq_cnt_d  = '0;
                end
            end
            UP: begin
                if (pg_done_i) begin
                    state_d = ON;
                    gnt_d   = req_i;
                    if (on_cnt_q != '1) begin
                        on_cnt_d = on_cnt_q + 1'b1;
                    end
                end else begin
                    // Counter holds at the watchdog limit; the state keeps waiting.
                    if (seq_cnt_q == SEQ_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        seq_cnt_d = seq_cnt_q + 1'b1;
                    end
                end
            end
            ON: begin
                gnt_d = req_i;
                if (!any_req) begin
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end
            end
            IDLE: begin
                gnt_d = '0;
                if (any_req) begin
                    state_d = ON;
                    gnt_d   = req_i;
                end else if (idle_cnt_q == idle_timeout_i) begin
                    state_d    = DOWN;
                    pg_power_d = 1'b0;
                    seq_cnt_d  = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            DOWN: begin
                gnt_d = '0;
                if (pg_done_i) begin
                    state_d = OFF;
                end else if (seq_cnt_q == SEQ_MAX) begin
                    err_d = 1'b1;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = OFF;
                pg_power_d = 1'b0;
                gnt_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= OFF;
            pg_power_q <= 1'b0;
            gnt_q      <= '0;
            err_q      <= 1'b0;
            on_cnt_q   <= '0;
            seq_cnt_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pg_power_q <= pg_power_d;
            gnt_q      <= gnt_d;
            err_q      <= err_d;
            on_cnt_q   <= on_cnt_d;
            seq_cnt_q  <= seq_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign pg_power_o = pg_power_q;
    assign state_o    = state_q;
    assign err_o      = err_q;
    assign on_cnt_o   = on_cnt_q;

endmodule

// File: tb/tb_mram_power_arbiter.sv
// Directed test of mram_power_arbiter: power-up, shared grant, idle timeout and
// rescue, request during power-down, watchdog and asynchronous reset.
module tb_mram_power_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_i;
    logic [2:0]  gnt_o;
    logic [15:0] idle_timeout_i;
    logic        pg_power_o;
    logic        pg_done_i;
    logic [2:0]  state_o;
    logic        err_o;
    logic [15:0] on_cnt_o;

    int checks = 0;
    int errors = 0;

    mram_power_arbiter #(
        .N_REQ(3),
        .TIMEOUT_W(16),
        .SEQ_TIMEOUT(64),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_i(req_i),
        .gnt_o(gnt_o),
        .idle_timeout_i(idle_timeout_i),
        .pg_power_o(pg_power_o),
        .pg_done_i(pg_done_i),
        .state_o(state_o),
        .err_o(err_o),
        .on_cnt_o(on_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full-state snapshot check: state, power, grant, err, count.
    task automatic chk_all(input string tag, input logic [2:0] st, input logic pw,
                           input logic [2:0] g, input logic e, input logic [15:0] c);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".power"}, 32'(pg_power_o), 32'(pw));
        chk({tag, ".gnt"}, 32'(gnt_o), 32'(g));
        chk({tag, ".err"}, 32'(err_o), 32'(e));
        chk({tag, ".cnt"}, 32'(on_cnt_o), 32'(c));
    endtask

    initial begin
        rst = 1'b0;
        req_i = 3'b000;
        pg_done_i = 1'b0;
        idle_timeout_i = 16'd3;
        #2;
        chk_all("reset", 3'd0, 1'b0, 3'b000, 1'b0, 16'd0);
        tick();
        #2 rst = 1'b1;
        tick();
        chk_all("off_idle", 3'd0, 1'b0, 3'b000, 1'b0, 16'd0);

        // Power-up: done arrives 5 cycles after power.
        req_i = 3'b001;
        tick();
        chk_all("up_entry", 3'd1, 1'b1, 3'b000, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) tick();
        chk_all("up_wait", 3'd1, 1'b1, 3'b000, 1'b0, 16'd0);
        pg_done_i = 1'b1;
        tick();
        chk_all("on_entry", 3'd2, 1'b1, 3'b001, 1'b0, 16'd1);

        // Shared grant, single drop, then idle power-down with timeout 3.
        req_i = 3'b011;
        tick();
        chk("shared.gnt", 32'(gnt_o), 32'h3);
        tick();
        chk("shared.hold", 32'(gnt_o), 32'h3);
        req_i = 3'b010;
        tick();
        chk("drop_one.gnt", 32'(gnt_o), 32'h2);
        req_i = 3'b000;
        tick();
        chk_all("idle_entry", 3'd3, 1'b1, 3'b000, 1'b0, 16'd1);
        tick(); tick(); tick();
        chk_all("idle_e3", 3'd3, 1'b1, 3'b000, 1'b0, 16'd1);
        tick();
        chk_all("down_entry", 3'd4, 1'b0, 3'b000, 1'b0, 16'd1);
        pg_done_i = 1'b0;
        tick(); tick();
        chk("down_wait.state", 32'(state_o), 32'd4);
        pg_done_i = 1'b1;
        tick();
        chk_all("off_after_down", 3'd0, 1'b0, 3'b000, 1'b0, 16'd1);

        // Idle rescue on the cycle the idle counter reaches the timeout.
        req_i = 3'b001;
        pg_done_i = 1'b0;
        tick();
        chk("rescue_up.state", 32'(state_o), 32'd1);
        tick();
        pg_done_i = 1'b1;
        tick();
        chk_all("rescue_on", 3'd2, 1'b1, 3'b001, 1'b0, 16'd2);
        req_i = 3'b000;
        tick();
        tick(); tick(); tick();
        chk("rescue_idle.state", 32'(state_o), 32'd3);
        req_i = 3'b100;
        tick();
        chk_all("rescue", 3'd2, 1'b1, 3'b100, 1'b0, 16'd2);

        // Request raised during DOWN is served only after power-down completes.
        req_i = 3'b000;
        tick();
        tick(); tick(); tick(); tick();
        chk_all("down2_entry", 3'd4, 1'b0, 3'b000, 1'b0, 16'd2);
        pg_done_i = 1'b0;
        req_i = 3'b010;
        tick();
        chk_all("down2_req", 3'd4, 1'b0, 3'b000, 1'b0, 16'd2);
        pg_done_i = 1'b1;
        tick();
        chk_all("down2_off", 3'd0, 1'b0, 3'b000, 1'b0, 16'd2);
        tick();
        chk_all("down2_reup", 3'd1, 1'b1, 3'b000, 1'b0, 16'd2);
        pg_done_i = 1'b0;
        tick();
        chk("down2_upwait.state", 32'(state_o), 32'd1);
        pg_done_i = 1'b1;
        tick();
        chk_all("down2_on", 3'd2, 1'b1, 3'b010, 1'b0, 16'd3);

        // Watchdog: fast power-down with timeout 0, then a hung power-up.
        idle_timeout_i = 16'd0;
        req_i = 3'b000;
        tick();
        chk("to0_idle.state", 32'(state_o), 32'd3);
        tick();
        chk_all("to0_down", 3'd4, 1'b0, 3'b000, 1'b0, 16'd3);
        tick();
        chk("to0_off.state", 32'(state_o), 32'd0);
        pg_done_i = 1'b0;
        req_i = 3'b001;
        tick();
        chk("wd_up.state", 32'(state_o), 32'd1);
        for (int i = 0; i < 63; i++) tick();
        chk_all("wd_e63", 3'd1, 1'b1, 3'b000, 1'b0, 16'd3);
        tick();
        chk_all("wd_e64", 3'd1, 1'b1, 3'b000, 1'b1, 16'd3);
        tick();
        chk("wd_hold.state", 32'(state_o), 32'd1);
        pg_done_i = 1'b1;
        tick();
        chk_all("wd_sticky", 3'd2, 1'b1, 3'b001, 1'b1, 16'd4);

        // Reset asserted mid-UP clears everything asynchronously.
        req_i = 3'b000;
        tick(); tick(); tick();
        chk("rst_prep.state", 32'(state_o), 32'd0);
        pg_done_i = 1'b0;
        req_i = 3'b001;
        tick();
        chk("rst_up.state", 32'(state_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_all("rst_async", 3'd0, 1'b0, 3'b000, 1'b0, 16'd0);
        tick();
        chk_all("rst_held", 3'd0, 1'b0, 3'b000, 1'b0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
